// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM state, grant encoding
// and default line/address widths.
package pmem_arb_types;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D    = 2'd2
  } grant_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one cacheline adaptor.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed D-over-I.
module pmem_arbiter
  import pmem_arb_types::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  state_t            state;
  grant_t            grant;
  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_req;
  logic              serving;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_d;
`endif

  assign d_req   = d_pmem_read | d_pmem_write;
  assign serving = (state == ST_SERVE_I) || (state == ST_SERVE_D);

  // Grant is only evaluated in IDLE; requests seen while busy are ignored.
  always_comb begin
    grant = GRANT_NONE;
    if (state == ST_IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && i_pmem_read) grant = last_d ? GRANT_I : GRANT_D;
      else if (d_req)           grant = GRANT_D;
      else if (i_pmem_read)     grant = GRANT_I;
`else
      if (d_req)                grant = GRANT_D;
      else if (i_pmem_read)     grant = GRANT_I;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant == GRANT_D) begin
            state     <= ST_SERVE_D;
            cmd_write <= d_pmem_write;
            cmd_read  <= ~d_pmem_write;
            addr_q    <= d_pmem_address;
            wdata_q   <= d_pmem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b1;
`endif
          end else if (grant == GRANT_I) begin
            state     <= ST_SERVE_I;
            cmd_write <= 1'b0;
            cmd_read  <= 1'b1;
            addr_q    <= i_pmem_address;
            wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (mem_resp) begin
            state     <= ST_RELEASE;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
          end
        end
        // RELEASE swallows a requester still holding read in its resp cycle.
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even mid-transaction.
  assign mem_read     = ~rst & cmd_read;
  assign mem_write    = ~rst & cmd_write;
  assign mem_address  = (serving && !rst) ? addr_q  : '0;
  assign mem_wdata    = (serving && !rst) ? wdata_q : '0;
  assign i_pmem_resp  = ~rst & (state == ST_SERVE_I) & mem_resp;
  assign d_pmem_resp  = ~rst & (state == ST_SERVE_D) & mem_resp;
  assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;

endmodule
